// File: rtl/cordic_seq.sv
// Iteration sequencer for an iterative CORDIC core.
// Accepts one operand set over valid/ready, pulses the core enable to load it, then steps
// shift/angle through ITER micro-rotations. The core outputs are captured on the last step
// and the result is held over a valid/ready handshake until it is taken.
module cordic_seq #(
  parameter int unsigned DW   = 16,
  parameter int unsigned SW   = 3,
  parameter int unsigned ITER = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic          i_in_mode,
  input  logic [DW-1:0] i_in_x,
  input  logic [DW-1:0] i_in_y,
  input  logic [DW-1:0] i_in_z,
  output logic          o_core_mode,
  output logic          o_core_enable,
  output logic [DW-1:0] o_core_x,
  output logic [DW-1:0] o_core_y,
  output logic [DW-1:0] o_core_z,
  output logic [SW-1:0] o_core_shift,
  output logic [DW-1:0] o_core_angle,
  input  logic [DW-1:0] i_core_x_o,
  input  logic [DW-1:0] i_core_y_o,
  input  logic [DW-1:0] i_core_z_o,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_out_x,
  output logic [DW-1:0] o_out_y,
  output logic [DW-1:0] o_out_z
);

  typedef enum logic [1:0] {StIdle, StLoad, StRot, StDone} state_t;

  localparam logic [SW-1:0] LastCnt = SW'(ITER - 1);

  state_t        r_state;
  logic [SW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_core_enable;
  logic          r_out_valid;
  logic          r_core_mode;
  logic [DW-1:0] r_core_x;
  logic [DW-1:0] r_core_y;
  logic [DW-1:0] r_core_z;
  logic [DW-1:0] r_core_angle;
  logic [DW-1:0] r_out_x;
  logic [DW-1:0] r_out_y;
  logic [DW-1:0] r_out_z;
  logic [SW-1:0] w_cnt_nxt;

  // atan(2^-i) with pi = 2^15, widened to the datapath by a left shift
  function automatic logic [DW-1:0] atan_lut(input logic [SW-1:0] idx);
    logic [15:0] v;
    case (int'(idx))
      0:       v = 16'd8192;
      1:       v = 16'd4836;
      2:       v = 16'd2555;
      3:       v = 16'd1297;
      4:       v = 16'd651;
      5:       v = 16'd326;
      6:       v = 16'd163;
      7:       v = 16'd81;
      default: v = 16'd0;
    endcase
    return DW'(v) << (DW - 16);
  endfunction

  assign w_cnt_nxt = r_cnt + 1'b1;

  // Sequencer FSM; all handshake and core-facing outputs are registered here
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_in_ready    <= 1'b1;
      r_core_enable <= 1'b0;
      r_out_valid   <= 1'b0;
      r_core_mode   <= 1'b0;
      r_core_x      <= '0;
      r_core_y      <= '0;
      r_core_z      <= '0;
      r_core_angle  <= '0;
      r_out_x       <= '0;
      r_out_y       <= '0;
      r_out_z       <= '0;
    end else if (i_clr) begin
      // Abort wins over any handshake; a pending result is simply dropped
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_in_ready    <= 1'b1;
      r_core_enable <= 1'b0;
      r_out_valid   <= 1'b0;
      r_core_angle  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            r_core_mode   <= i_in_mode;
            r_core_x      <= i_in_x;
            r_core_y      <= i_in_y;
            r_core_z      <= i_in_z;
            r_in_ready    <= 1'b0;
            r_core_enable <= 1'b1;
            r_state       <= StLoad;
          end
        end
        StLoad: begin
          r_core_enable <= 1'b0;
          r_cnt         <= '0;
          r_core_angle  <= atan_lut('0);
          r_state       <= StRot;
        end
        StRot: begin
          if (r_cnt == LastCnt) begin
            r_out_x      <= i_core_x_o;
            r_out_y      <= i_core_y_o;
            r_out_z      <= i_core_z_o;
            r_out_valid  <= 1'b1;
            r_cnt        <= '0;
            r_core_angle <= '0;
            r_state      <= StDone;
          end else begin
            r_cnt        <= w_cnt_nxt;
            r_core_angle <= atan_lut(w_cnt_nxt);
          end
        end
        StDone: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_in_ready    = r_in_ready;
  assign o_core_mode   = r_core_mode;
  assign o_core_enable = r_core_enable;
  assign o_core_x      = r_core_x;
  assign o_core_y      = r_core_y;
  assign o_core_z      = r_core_z;
  // The count is cleared on every exit from ROT, so it doubles as the shift
  assign o_core_shift  = r_cnt;
  assign o_core_angle  = r_core_angle;
  assign o_out_valid   = r_out_valid;
  assign o_out_x       = r_out_x;
  assign o_out_y       = r_out_y;
  assign o_out_z       = r_out_z;

endmodule
